// File: rtl/icache_refill_ctrl_if.sv
// Interface bundling the fetch-side miss handshake, the instruction-memory burst
// read channel and the cache SRAM block-write port of icache_refill_ctrl.
//   miss_*   : fetch -> refill engine miss handshake (miss_ready back to fetch)
//   mem_*    : burst read request / grant / data beats to instruction memory
//   cache_*  : single-cycle block write into the cache SRAM
//   busy, refill_done : status back to fetch
// Modports: slave = refill engine, master = fetch/memory/SRAM environment.
interface icache_refill_ctrl_if #(
    parameter int unsigned BLOCK_WORDS     = 4,
    parameter int unsigned WORD_BITS       = 32,
    parameter int unsigned BLOCK_ADDR_BITS = 10
);
    localparam int unsigned MemAddrBits = BLOCK_ADDR_BITS + $clog2(BLOCK_WORDS);

    logic                             miss_valid;
    logic [BLOCK_ADDR_BITS-1:0]       miss_block_addr;
    logic                             miss_ready;
    logic                             mem_req;
    logic [MemAddrBits-1:0]           mem_addr;
    logic                             mem_gnt;
    logic                             mem_rvalid;
    logic [WORD_BITS-1:0]             mem_rdata;
    logic                             cache_wen;
    logic [BLOCK_ADDR_BITS-1:0]       cache_block_addr;
    logic [BLOCK_WORDS*WORD_BITS-1:0] cache_data;
    logic                             busy;
    logic                             refill_done;

    modport slave (
        input  miss_valid, miss_block_addr, mem_gnt, mem_rvalid, mem_rdata,
        output miss_ready, mem_req, mem_addr, cache_wen, cache_block_addr, cache_data,
               busy, refill_done
    );

    modport master (
        output miss_valid, miss_block_addr, mem_gnt, mem_rvalid, mem_rdata,
        input  miss_ready, mem_req, mem_addr, cache_wen, cache_block_addr, cache_data,
               busy, refill_done
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill engine. Accepts one block miss from fetch, issues a
// single burst read to instruction memory, assembles the returned beats into a full
// block and writes it into the cache SRAM in one cycle, then pulses refill_done.
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   bus_io : icache_refill_ctrl_if.slave (miss handshake, memory burst, SRAM write,
//            busy / refill_done status)
module icache_refill_ctrl #(
    parameter int unsigned BLOCK_WORDS     = 4,
    parameter int unsigned WORD_BITS       = 32,
    parameter int unsigned BLOCK_ADDR_BITS = 10
) (
    input logic                 clk,
    input logic                 rst,
    icache_refill_ctrl_if.slave bus_io
);
    localparam int unsigned CntW = $clog2(BLOCK_WORDS);
    localparam logic [CntW-1:0] LastCnt = CntW'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRecv,
        StFill,
        StDone
    } state_e;

    state_e                           state_q, state_d;
    logic [CntW-1:0]                  cnt_q, cnt_d;
    logic [BLOCK_ADDR_BITS-1:0]       addr_q, addr_d;
    logic [BLOCK_WORDS*WORD_BITS-1:0] data_q, data_d;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (bus_io.miss_valid) begin
                    addr_d  = bus_io.miss_block_addr;
                    cnt_d   = '0;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus_io.mem_gnt) begin
                    state_d = StRecv;
                end
            end
            StRecv: begin
                if (bus_io.mem_rvalid) begin
                    for (int k = 0; k < int'(BLOCK_WORDS); k++) begin
                        if (cnt_q == CntW'(k)) begin
                            data_d[k*WORD_BITS +: WORD_BITS] = bus_io.mem_rdata;
                        end
                    end
                    // Counter parks on the last slot instead of wrapping.
                    if (cnt_q == LastCnt) begin
                        state_d = StFill;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StFill: state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from registered state only, so no input reaches
    // mem_req or cache_wen combinationally.
    always_comb begin
        bus_io.miss_ready       = (state_q == StIdle);
        bus_io.busy             = (state_q != StIdle);
        bus_io.mem_req          = (state_q == StReq);
        bus_io.cache_wen        = (state_q == StFill);
        bus_io.refill_done      = (state_q == StDone);
        bus_io.mem_addr         = {addr_q, {CntW{1'b0}}};
        bus_io.cache_block_addr = addr_q;
        bus_io.cache_data       = data_q;
    end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;
    localparam int BW = 4;
    localparam int WB = 32;
    localparam int AB = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   wen_cnt = 0;
    int   nref = 0;

    int             g[BW];
    logic [WB-1:0]  w[BW];

    icache_refill_ctrl_if #(.BLOCK_WORDS(BW), .WORD_BITS(WB), .BLOCK_ADDR_BITS(AB)) bus ();

    icache_refill_ctrl #(
        .BLOCK_WORDS(BW),
        .WORD_BITS(WB),
        .BLOCK_ADDR_BITS(AB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_io(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.cache_wen === 1'b1) wen_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)",
                 checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full refill driven from the memory side; expected values come from
    // the block address and word list with plain arithmetic.
    task automatic refill(input logic [AB-1:0] a, input int gdly, input int gaps[BW],
                          input logic [WB-1:0] words[BW], input bit hold,
                          input logic [AB-1:0] next_a, input bit expect_now);
        int waits;
        int lat;
        int wen0;
        int exp_lat;
        int ma;
        bit ready;
        logic [127:0] exp_data;
        waits = 0;
        lat = 0;
        ready = 0;
        ma = int'(a) * BW;
        exp_data = '0;
        exp_lat = 1 + gdly + BW + 1;
        for (int k = 0; k < BW; k++) begin
            exp_data = exp_data | (128'(words[k]) << (k * WB));
            exp_lat += gaps[k];
        end
        nref++;
        bus.miss_valid = 1'b1;
        bus.miss_block_addr = a;
        while (!ready && waits < 50) begin
            @(negedge clk);
            if (bus.miss_ready === 1'b1) ready = 1;
            else waits++;
        end
        chk("accept_ready", ready, 1'b1);
        if (expect_now) chk("accept_first_idle_waits", waits, 0);
        tick();
        wen0 = wen_cnt;
        if (!hold) bus.miss_valid = 1'b0;
        for (int i = 0; i <= gdly; i++) begin
            bus.mem_gnt = (i == gdly);
            @(negedge clk);
            chk("req_mem_req", bus.mem_req, 1'b1);
            chk("req_mem_addr", bus.mem_addr, ma);
            chk("req_miss_ready", bus.miss_ready, 1'b0);
            tick();
            lat++;
        end
        bus.mem_gnt = 1'b0;
        for (int k = 0; k < BW; k++) begin
            for (int j = 0; j < gaps[k]; j++) begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata = $urandom;
                @(negedge clk);
                chk("recv_mem_req", bus.mem_req, 1'b0);
                chk("recv_busy", bus.busy, 1'b1);
                tick();
                lat++;
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = words[k];
            if (hold && k == 0) bus.miss_block_addr = next_a;
            @(negedge clk);
            chk("recv_no_wen", bus.cache_wen, 1'b0);
            tick();
            lat++;
        end
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = $urandom;
        @(negedge clk);
        chk("fill_wen", bus.cache_wen, 1'b1);
        chk("fill_block_addr", bus.cache_block_addr, a);
        chk("fill_data", bus.cache_data, exp_data);
        chk("fill_done_low", bus.refill_done, 1'b0);
        tick();
        lat++;
        @(negedge clk);
        chk("done_pulse", bus.refill_done, 1'b1);
        chk("done_wen_low", bus.cache_wen, 1'b0);
        chk("done_miss_ready", bus.miss_ready, 1'b0);
        chk("done_busy", bus.busy, 1'b1);
        chk("done_latency", lat, exp_lat);
        chk("done_wen_once", wen_cnt - wen0, 1);
        chk("done_hold_data", bus.cache_data, exp_data);
        tick();
    endtask

    initial begin
        bus.miss_valid = 1'b0;
        bus.miss_block_addr = '0;
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        for (int k = 0; k < BW; k++) g[k] = 0;

        // Reset state.
        #2;
        chk("rst_miss_ready", bus.miss_ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_wen", bus.cache_wen, 1'b0);
        chk("rst_done", bus.refill_done, 1'b0);
        chk("rst_block_addr", bus.cache_block_addr, 0);
        chk("rst_data", bus.cache_data, 0);
        tick();
        tick();
        rst = 1'b0;

        // Basic refill, minimum latency.
        w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
        refill(10'h2A5, 0, g, w, 1'b0, '0, 1'b0);
        chk("basic_block_const", bus.cache_data,
            128'h44444444_33333333_22222222_11111111);

        // Delayed grant and gappy beats.
        for (int k = 0; k < BW; k++) g[k] = (k == 0) ? 0 : 2;
        w[0] = 32'hDEADBEEF; w[1] = 32'h01234567; w[2] = 32'h89ABCDEF; w[3] = 32'hCAFEF00D;
        refill(10'h3C1, 3, g, w, 1'b0, '0, 1'b0);

        // Reset mid-RECV.
        bus.miss_valid = 1'b1;
        bus.miss_block_addr = 10'h155;
        @(negedge clk);
        chk("rstmid_ready", bus.miss_ready, 1'b1);
        tick();
        bus.miss_valid = 1'b0;
        bus.mem_gnt = 1'b1;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hAAAA0001;
        tick();
        bus.mem_rdata = 32'hAAAA0002;
        tick();
        bus.mem_rvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_busy", bus.busy, 1'b0);
        chk("rstmid_ready_async", bus.miss_ready, 1'b1);
        chk("rstmid_data", bus.cache_data, 0);
        chk("rstmid_mem_req", bus.mem_req, 1'b0);
        tick();
        rst = 1'b0;
        begin
            int w0;
            w0 = wen_cnt;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = 32'hAAAA0003;
            tick();
            bus.mem_rdata = 32'hAAAA0004;
            tick();
            bus.mem_rvalid = 1'b0;
            tick();
            @(negedge clk);
            chk("rstmid_after_busy", bus.busy, 1'b0);
            chk("rstmid_after_ready", bus.miss_ready, 1'b1);
            chk("rstmid_after_data", bus.cache_data, 0);
            chk("rstmid_no_wen", wen_cnt - w0, 0);
        end
        tick();

        // Spurious grant / beats in IDLE, then a normal refill.
        bus.mem_gnt = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'h5A5A5A5A;
        tick();
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        chk("spur_busy", bus.busy, 1'b0);
        chk("spur_mem_req", bus.mem_req, 1'b0);
        chk("spur_data", bus.cache_data, 0);
        tick();
        for (int k = 0; k < BW; k++) begin
            g[k] = 0;
            w[k] = 32'hA + k;
        end
        refill(10'h001, 0, g, w, 1'b0, '0, 1'b0);
        chk("spur_block_const", bus.cache_data,
            128'h0000000D_0000000C_0000000B_0000000A);

        // Miss held while busy with a changing address.
        w[0] = 32'h10000001; w[1] = 32'h10000002; w[2] = 32'h10000003; w[3] = 32'h10000004;
        refill(10'h100, 1, g, w, 1'b1, 10'h200, 1'b0);
        w[0] = 32'h20000001; w[1] = 32'h20000002; w[2] = 32'h20000003; w[3] = 32'h20000004;
        refill(10'h200, 0, g, w, 1'b0, '0, 1'b1);

        // Randomized refills.
        for (int r = 0; r < 8; r++) begin
            logic [AB-1:0] ra;
            int gd;
            ra = AB'($urandom_range(0, 1023));
            gd = $urandom_range(0, 3);
            for (int k = 0; k < BW; k++) begin
                g[k] = $urandom_range(0, 2);
                w[k] = $urandom;
            end
            refill(ra, gd, g, w, 1'b0, '0, 1'b0);
            if ($urandom_range(0, 1) == 1) tick();
        end

        tick();
        @(negedge clk);
        chk("end_idle_ready", bus.miss_ready, 1'b1);
        chk("end_wen_total", wen_cnt, nref);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
